// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, selects and reset constants
package cp0_pkg;

   localparam logic [4:0]  CP0_COUNT     = 5'd9;
   localparam logic [4:0]  CP0_COMPARE   = 5'd11;
   localparam logic [4:0]  CP0_TIMER_EXT = 5'd22;
   localparam logic [2:0]  TICLR_SEL     = 3'd7;
   localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

   function automatic logic reg_hit(input logic [4:0] reg_num, input logic [2:0] sel,
                                    input logic [4:0] want_num, input logic [2:0] want_sel);
      return (reg_num == want_num) && (sel == want_sel);
   endfunction

endpackage

// File: rtl/cp0_timer_cmp_channel.sv
// rtl/cp0_timer_cmp_channel.sv - one Compare/Period channel with its pending bit
module cp0_timer_cmp_channel
   import cp0_pkg::*;
#(
   parameter bit PERIODIC_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        count_write,
   input  logic [31:0] count_next,
   input  logic        cmp_wr,
   input  logic        period_wr,
   input  logic        ticlr,
   input  logic [31:0] wdata,
   output logic [31:0] compare,
   output logic [31:0] period,
   output logic        ti
);

   logic match;

   // Fires only when Count steps onto Compare, never when Count is loaded onto it.
   assign match = tick & ~count_write & (count_next == compare);

   always_ff @(posedge clk) begin
      if (reset) begin
         compare <= COMPARE_RESET;
         ti      <= 1'b0;
      end else begin
         if (cmp_wr)
            compare <= wdata;
         else if (match && (period != 32'd0))
            compare <= compare + period;

         if (cmp_wr)
            ti <= 1'b0;
         else if (match)
            ti <= 1'b1;
         else if (ticlr)
            ti <= 1'b0;
      end
   end

   generate
      if (PERIODIC_EN) begin : g_period
         always_ff @(posedge clk) begin
            if (reset)
               period <= 32'd0;
            else if (period_wr)
               period <= wdata;
         end
      end else begin : g_no_period
         assign period = 32'd0;
      end
   endgenerate

endmodule

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count with prescaler, multi-channel Compare and timer interrupt
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int NUM_CMP     = 1,
   parameter int COUNT_DIV   = 2,
   parameter bit PERIODIC_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wen,
   input  logic [4:0]         reg_num,
   input  logic [2:0]         sel,
   input  logic [31:0]        reg_in,
   output logic [31:0]        reg_out,
   input  logic               count_dc,
   output logic [NUM_CMP-1:0] ti,
   output logic               ti_any,
   output logic [31:0]        count_out
);

   logic        tick;
   logic        count_write;
   logic [31:0] count;
   logic [31:0] count_next;
   logic [31:0] compare [NUM_CMP];
   logic [31:0] period  [NUM_CMP];

   generate
      if (COUNT_DIV == 1) begin : g_no_pre
         assign tick = ~count_dc;
      end else begin : g_pre
         localparam int PRE_W = $clog2(COUNT_DIV);
         logic [PRE_W-1:0] prescaler;

         // COUNT_DIV is a power of two, so the natural wrap of the counter is the divide.
         always_ff @(posedge clk) begin
            if (reset)
               prescaler <= '0;
            else if (!count_dc)
               prescaler <= prescaler + PRE_W'(1);
         end

         assign tick = (prescaler == '0) & ~count_dc;
      end
   endgenerate

   assign count_write = wen & reg_hit(reg_num, sel, CP0_COUNT, 3'd0);
   assign count_next  = count + 32'd1;

   always_ff @(posedge clk) begin
      if (reset)
         count <= 32'd0;
      else if (count_write)
         count <= reg_in;
      else if (tick)
         count <= count_next;
   end

   generate
      for (genvar k = 0; k < NUM_CMP; k++) begin : g_ch
         cp0_timer_cmp_channel #(.PERIODIC_EN(PERIODIC_EN)) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .count_write (count_write),
            .count_next  (count_next),
            .cmp_wr      (wen & reg_hit(reg_num, sel, CP0_COMPARE, 3'(k))),
            .period_wr   (wen & reg_hit(reg_num, sel, CP0_TIMER_EXT, 3'(k))),
            .ticlr       (wen & reg_hit(reg_num, sel, CP0_TIMER_EXT, TICLR_SEL) & reg_in[k]),
            .wdata       (reg_in),
            .compare     (compare[k]),
            .period      (period[k]),
            .ti          (ti[k])
         );
      end
   endgenerate

   always_comb begin
      reg_out = 32'd0;
      case (reg_num)
         CP0_COUNT: begin
            if (sel == 3'd0)
               reg_out = count;
         end
         CP0_COMPARE: begin
            for (int k = 0; k < NUM_CMP; k++)
               if (sel == 3'(k))
                  reg_out = compare[k];
         end
         CP0_TIMER_EXT: begin
            if (sel == TICLR_SEL)
               reg_out = 32'(ti);
            for (int k = 0; k < NUM_CMP; k++)
               if (sel == 3'(k))
                  reg_out = period[k];
         end
         default: reg_out = 32'd0;
      endcase
   end

   assign ti_any    = |ti;
   assign count_out = count;

endmodule

// File: tb/tb_cp0_timer.sv
// tb/tb_cp0_timer.sv - randomized bench for cp0_timer against a behavioural model
module tb_cp0_timer;

   logic        clk = 1'b0;
   logic        reset, wen, count_dc;
   logic [4:0]  reg_num;
   logic [2:0]  sel;
   logic [31:0] reg_in;
   logic [31:0] ro0, co0, ro1, co1;
   logic [1:0]  ti0;
   logic [2:0]  ti1;
   logic        tia0, tia1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cp0_timer #(.NUM_CMP(2), .COUNT_DIV(2), .PERIODIC_EN(1'b1)) dut0 (
      .clk(clk), .reset(reset), .wen(wen), .reg_num(reg_num), .sel(sel), .reg_in(reg_in),
      .reg_out(ro0), .count_dc(count_dc), .ti(ti0), .ti_any(tia0), .count_out(co0));

   cp0_timer #(.NUM_CMP(3), .COUNT_DIV(1), .PERIODIC_EN(1'b0)) dut1 (
      .clk(clk), .reset(reset), .wen(wen), .reg_num(reg_num), .sel(sel), .reg_in(reg_in),
      .reg_out(ro1), .count_dc(count_dc), .ti(ti1), .ti_any(tia1), .count_out(co1));

   // Reference model: one slot per DUT instance
   int unsigned m_div  [2];
   int          m_ncmp [2];
   bit          m_pen  [2];
   logic [31:0] m_count[2];
   int unsigned m_cyc  [2];
   logic [31:0] m_cmp  [2][4];
   logic [31:0] m_per  [2][4];
   bit          m_ti   [2][4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_tivec(input int i);
      logic [31:0] v = 32'd0;
      for (int k = 0; k < m_ncmp[i]; k++) v[k] = m_ti[i][k];
      return v;
   endfunction

   function automatic logic [31:0] m_read(input int i);
      int s = int'(sel);
      if (reg_num == 5'd9 && s == 0) return m_count[i];
      if (reg_num == 5'd11 && s < m_ncmp[i]) return m_cmp[i][s];
      if (reg_num == 5'd22 && s < m_ncmp[i]) return m_pen[i] ? m_per[i][s] : 32'd0;
      if (reg_num == 5'd22 && s == 7) return m_tivec(i);
      return 32'd0;
   endfunction

   function automatic bit m_will_match(input int i, input int k);
      return (m_cyc[i] % m_div[i] == 0) && (m_count[i] + 32'd1 == m_cmp[i][k]);
   endfunction

   task automatic m_step(input int i);
      bit cw, tick, mt;
      if (reset) begin
         m_count[i] = 32'd0;
         m_cyc[i]   = 0;
         for (int k = 0; k < 4; k++) begin
            m_cmp[i][k] = 32'hFFFF_FFFF;
            m_per[i][k] = 32'd0;
            m_ti[i][k]  = 1'b0;
         end
         return;
      end
      cw   = wen && reg_num == 5'd9 && sel == 3'd0;
      tick = !count_dc && (m_cyc[i] % m_div[i] == 0);
      for (int k = 0; k < m_ncmp[i]; k++) begin
         mt = tick && !cw && (m_count[i] + 32'd1 == m_cmp[i][k]);
         if (wen && reg_num == 5'd11 && int'(sel) == k) begin
            m_cmp[i][k] = reg_in;
            m_ti[i][k]  = 1'b0;
         end else if (mt) begin
            m_ti[i][k] = 1'b1;
            if (m_pen[i] && m_per[i][k] != 0) m_cmp[i][k] = m_cmp[i][k] + m_per[i][k];
         end else if (wen && reg_num == 5'd22 && sel == 3'd7 && reg_in[k]) begin
            m_ti[i][k] = 1'b0;
         end
         if (m_pen[i] && wen && reg_num == 5'd22 && int'(sel) == k) m_per[i][k] = reg_in;
      end
      if (cw) m_count[i] = reg_in;
      else if (tick) m_count[i] = m_count[i] + 32'd1;
      if (!count_dc) m_cyc[i]++;
   endtask

   task automatic cyc(input bit w, input logic [4:0] rn, input logic [2:0] s,
                      input logic [31:0] d, input bit dc, input bit rst);
      @(negedge clk);
      wen = w; reg_num = rn; sel = s; reg_in = d; count_dc = dc; reset = rst;
      #1;
      chk("i0_reg_out", ro0, m_read(0));
      chk("i0_count",   co0, m_count[0]);
      chk("i0_ti",      32'(ti0), m_tivec(0));
      chk("i0_ti_any",  32'(tia0), 32'(m_tivec(0) != 0));
      chk("i1_reg_out", ro1, m_read(1));
      chk("i1_count",   co1, m_count[1]);
      chk("i1_ti",      32'(ti1), m_tivec(1));
      chk("i1_ti_any",  32'(tia1), 32'(m_tivec(1) != 0));
      m_step(0);
      m_step(1);
   endtask

   task automatic idle(input logic [4:0] rn, input logic [2:0] s, input int n);
      for (int j = 0; j < n; j++) cyc(1'b0, rn, s, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bit found;
      logic [4:0]  rn;
      logic [2:0]  s;
      logic [31:0] d;
      m_div  = '{2, 1};
      m_ncmp = '{2, 3};
      m_pen  = '{1'b1, 1'b0};
      wen = 1'b0; reg_num = 5'd9; sel = 3'd0; reg_in = 32'd0; count_dc = 1'b0; reset = 1'b1;
      m_step(0);
      m_step(1);

      cyc(1'b0, 5'd9, 3'd0, 32'd0, 1'b0, 1'b1);
      idle(5'd9, 3'd0, 10);
      @(posedge clk); #1;
      chk("count_after_10_div2", co0, 32'd5);
      chk("reg_out_after_10_div2", ro0, 32'd5);
      chk("count_after_10_div1", co1, 32'd10);

      // Compare[0]=8 match, then rewrite to 20 right after ti rises
      cyc(1'b1, 5'd11, 3'd0, 32'd8, 1'b0, 1'b0);
      found = 1'b0;
      for (int j = 0; j < 40 && !found; j++) begin
         idle(5'd11, 3'd0, 1);
         found = m_ti[0][0];
      end
      chk("cmp0_match_seen", 32'(found), 32'd1);
      cyc(1'b1, 5'd11, 3'd0, 32'd20, 1'b0, 1'b0);
      idle(5'd22, 3'd7, 3);

      // Loading Count onto Compare does not fire; wrap onto Compare=0 does
      cyc(1'b1, 5'd11, 3'd0, 32'd8, 1'b0, 1'b0);
      cyc(1'b1, 5'd9, 3'd0, 32'd8, 1'b0, 1'b0);
      idle(5'd22, 3'd7, 4);
      cyc(1'b1, 5'd11, 3'd0, 32'd0, 1'b0, 1'b0);
      cyc(1'b1, 5'd9, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      idle(5'd9, 3'd0, 4);

      // Periodic reload on channel 1, TIClr, then TIClr coincident with a match
      cyc(1'b1, 5'd9, 3'd0, 32'd5, 1'b0, 1'b0);
      cyc(1'b1, 5'd22, 3'd1, 32'd4, 1'b0, 1'b0);
      cyc(1'b1, 5'd11, 3'd1, 32'd10, 1'b0, 1'b0);
      idle(5'd11, 3'd1, 14);
      cyc(1'b1, 5'd22, 3'd7, 32'd2, 1'b0, 1'b0);
      found = 1'b0;
      for (int j = 0; j < 40 && !found; j++) begin
         if (m_will_match(0, 1)) begin
            cyc(1'b1, 5'd22, 3'd7, 32'd2, 1'b0, 1'b0);
            found = 1'b1;
         end else begin
            idle(5'd11, 3'd1, 1);
         end
      end
      chk("ticlr_coincident_reached", 32'(found), 32'd1);
      idle(5'd22, 3'd7, 3);

      // Count freeze via count_dc
      for (int j = 0; j < 7; j++) cyc(1'b0, 5'd9, 3'd0, 32'd0, 1'b1, 1'b0);
      idle(5'd9, 3'd0, 5);

      // Compare write coincident with a match
      cyc(1'b1, 5'd11, 3'd0, m_count[0] + 32'd3, 1'b0, 1'b0);
      found = 1'b0;
      for (int j = 0; j < 40 && !found; j++) begin
         if (m_will_match(0, 0)) begin
            cyc(1'b1, 5'd11, 3'd0, 32'h123, 1'b0, 1'b0);
            found = 1'b1;
         end else begin
            idle(5'd11, 3'd0, 1);
         end
      end
      chk("cmp_write_coincident_reached", 32'(found), 32'd1);
      idle(5'd11, 3'd0, 2);
      idle(5'd11, 3'd3, 1);
      idle(5'd11, 3'd2, 1);
      idle(5'd22, 3'd3, 1);
      idle(5'd22, 3'd7, 1);

      // Randomized traffic biased toward timer registers and near-match values
      for (int j = 0; j < 3000; j++) begin
         case ($urandom_range(0, 3))
            0: rn = 5'd9;
            1: rn = 5'd11;
            2: rn = 5'd22;
            default: rn = 5'($urandom);
         endcase
         s = ($urandom_range(0, 3) == 0) ? 3'd7 :
             ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         if (rn == 5'd11)
            d = m_count[$urandom_range(0, 1)] + 32'($urandom_range(0, 12));
         else if (rn == 5'd22 && s != 3'd7)
            d = 32'($urandom_range(0, 5));
         else if (rn == 5'd9)
            d = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : m_cmp[0][$urandom_range(0, 1)] - 32'($urandom_range(0, 3));
         else
            d = $urandom;
         cyc(($urandom_range(0, 2) == 0), rn, s, d,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
